score_segment_driver: RTL and testbench
=======================================

SCORE_SEGMENT_DRIVER -- requirements
Module: score_segment_driver

Interface
REQ-001 Parameter WIN_SCORE, default 7, meaning: score (1..9) at which a player wins.
REQ-002 Parameter HOLD_FRAMES, default 60, meaning: frames of serve hold-off after each point (1..255).
REQ-003 Port clk  input  1  system/pixel clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port new_frame  input  1  one-cycle pulse at start of vertical blanking.
REQ-006 Port point_l  input  1  one-cycle pulse: left player scored.
REQ-007 Port point_r  input  1  one-cycle pulse: right player scored.
REQ-008 Port game_reset  input  1  one-cycle pulse: start a new game.
REQ-009 Port seg_l  output  7  left digit segments, bit0=a … bit6=g, active high.
REQ-010 Port seg_r  output  7  right digit segments, same encoding.
REQ-011 Port serve_en  output  1  high while ball play is permitted.
REQ-012 Port game_over  output  1  high once a player reaches WIN_SCORE.
REQ-013 Port winner  output  2  2'b01 left won, 2'b10 right won, 2'b00 none.

Function
REQ-014 The block SHALL hold two 4-bit scores, score_l and score_r, each in range 0..9.
REQ-015 The block SHALL implement states PLAY, HOLD, OVER; serve_en SHALL be 1 only in PLAY.
REQ-016 In PLAY, point_l alone SHALL increment score_l on that clock edge; point_r alone SHALL increment score_r.
REQ-017 In PLAY, point_l and point_r asserted in the same cycle SHALL be ignored: no score change, state stays PLAY.
REQ-018 After a counted point, if the new score equals WIN_SCORE the next state SHALL be OVER, otherwise HOLD.
REQ-019 Point pulses in HOLD or OVER SHALL be ignored.
REQ-020 On entering HOLD, an 8-bit frame counter SHALL load 0; each new_frame in HOLD SHALL increment it.
REQ-021 On the new_frame that brings the counter to HOLD_FRAMES, the state SHALL return to PLAY on that edge.
REQ-022 In OVER, game_over SHALL be 1 and winner SHALL identify the scoring player; both SHALL be 0 in PLAY and HOLD.
REQ-023 OVER SHALL persist until game_reset.
REQ-024 game_reset, in any state, SHALL clear both scores, the frame counter, game_over and winner, and enter PLAY on that edge.
REQ-025 game_reset SHALL take priority over a point pulse in the same cycle.
REQ-026 seg_l/seg_r SHALL be registered and update only on the edge where new_frame is high.
  - The update SHALL use the scores as they stand before that edge.
  - Display changes therefore never tear mid-frame.
REQ-027 Segment encoding SHALL be 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F.
REQ-028 Score values 10..15 SHALL never occur; if present, the decoder SHALL output 7'h00.
REQ-029 A point and new_frame in the same cycle SHALL increment the score on that edge, but the display SHALL show the old score until the following new_frame.

Reset
REQ-030 On rst_n low, independent of clk, the block SHALL force:
  - scores = 0 and frame counter = 0
  - state = PLAY, serve_en = 1
  - seg_l = seg_r = 7'h3F
  - game_over = 0, winner = 2'b00
REQ-031 After rst_n deasserts, normal operation SHALL begin on the first rising clk edge.

Verification
REQ-032 Single point: reset, pulse point_l, then pulse new_frame -> serve_en drops to 0 the cycle after point_l; seg_l = 7'h06 after new_frame; seg_r = 7'h3F.
REQ-033 Hold-off: with HOLD_FRAMES=3, after a point -> serve_en stays 0 through 2 new_frame pulses and returns to 1 after the 3rd; point_r pulses during HOLD leave seg_r at 7'h3F.
REQ-034 Simultaneous points: point_l and point_r pulsed in the same cycle in PLAY -> scores unchanged, serve_en remains 1.
REQ-035 Win: WIN_SCORE=7, right side scores 7 times with holds elapsed -> game_over=1, winner=2'b10, seg_r=7'h07 after the next new_frame; further point_r is ignored.
REQ-036 New game: game_reset and point_l in the same cycle while in OVER -> game_over=0, state PLAY, both scores 0; seg outputs = 7'h3F after the next new_frame.
REQ-037 Async reset mid-HOLD: drop rst_n between clk edges -> all outputs reach reset values immediately, with no clk edge.

Source files
------------

// File: rtl/score_segment_driver.sv
// Pong-style score keeper: two decimal scores, PLAY/HOLD/OVER serve control,
// and frame-synchronous seven-segment outputs for the two score digits.
module score_segment_driver #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_frame,
  input  logic       point_l,
  input  logic       point_r,
  input  logic       game_reset,
  output logic [6:0] seg_l,
  output logic [6:0] seg_r,
  output logic       serve_en,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SEG_W   = 7;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HOLD = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEG_W-1:0]   seg_l_q, seg_l_d;
  logic [SEG_W-1:0]   seg_r_q, seg_r_d;
  logic               serve_en_q, serve_en_d;
  logic               game_over_q, game_over_d;
  logic [1:0]         winner_q, winner_d;
  logic [SCORE_W-1:0] score_l_inc, score_r_inc;
  logic [CNT_W-1:0]   cnt_inc;

  // Digit decoder; out-of-range values blank the digit.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [SCORE_W-1:0] v);
    case (v)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    cnt_d       = cnt_q;
    seg_l_d     = seg_l_q;
    seg_r_d     = seg_r_q;
    winner_d    = winner_q;
    score_l_inc = score_l_q + SCORE_W'(1);
    score_r_inc = score_r_q + SCORE_W'(1);
    cnt_inc     = cnt_q + CNT_W'(1);

    // Display samples the pre-edge scores so a point never tears a frame.
    if (new_frame) begin
      seg_l_d = seg_decode(score_l_q);
      seg_r_d = seg_decode(score_r_q);
    end

    if (game_reset) begin
      state_d   = ST_PLAY;
      score_l_d = '0;
      score_r_d = '0;
      cnt_d     = '0;
      winner_d  = 2'b00;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (point_l && !point_r) begin
            score_l_d = score_l_inc;
            cnt_d     = '0;
            if (score_l_inc == SCORE_W'(WIN_SCORE)) begin
              state_d  = ST_OVER;
              winner_d = 2'b01;
            end else begin
              state_d = ST_HOLD;
            end
          end else if (point_r && !point_l) begin
            score_r_d = score_r_inc;
            cnt_d     = '0;
            if (score_r_inc == SCORE_W'(WIN_SCORE)) begin
              state_d  = ST_OVER;
              winner_d = 2'b10;
            end else begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (new_frame) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(HOLD_FRAMES)) begin
              state_d = ST_PLAY;
            end
          end
        end
        ST_OVER: begin
          state_d = ST_OVER;
        end
        default: begin
          state_d = ST_PLAY;
        end
      endcase
    end

    serve_en_d  = (state_d == ST_PLAY);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PLAY;
      score_l_q   <= '0;
      score_r_q   <= '0;
      cnt_q       <= '0;
      seg_l_q     <= 7'h3F;
      seg_r_q     <= 7'h3F;
      serve_en_q  <= 1'b1;
      game_over_q <= 1'b0;
      winner_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      cnt_q       <= cnt_d;
      seg_l_q     <= seg_l_d;
      seg_r_q     <= seg_r_d;
      serve_en_q  <= serve_en_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign seg_l     = seg_l_q;
  assign seg_r     = seg_r_q;
  assign serve_en  = serve_en_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_score_segment_driver.sv
// Bench for score_segment_driver: table-driven vectors plus hand-written
// sequences for win, new game and asynchronous reset; expectations via a queue.
module tb_score_segment_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       new_frame, point_l, point_r, game_reset;
  logic [6:0] seg_l, seg_r;
  logic       serve_en, game_over;
  logic [1:0] winner;

  typedef struct packed {
    logic [6:0] sl;
    logic [6:0] sr;
    logic       se;
    logic       go;
    logic [1:0] w;
  } exp_t;

  typedef struct {
    logic  nf, pl, pr, gr;
    exp_t  e;
    string nm;
  } vec_t;

  exp_t       exp_q[$];
  string      name_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [6:0] seg_tab [10];
  logic [6:0] disp_r;

  score_segment_driver #(.WIN_SCORE(7), .HOLD_FRAMES(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .new_frame  (new_frame),
    .point_l    (point_l),
    .point_r    (point_r),
    .game_reset (game_reset),
    .seg_l      (seg_l),
    .seg_r      (seg_r),
    .serve_en   (serve_en),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [6:0] sl, input logic [6:0] sr,
                              input logic se, input logic go, input logic [1:0] w);
    exp_t e;
    e.sl = sl; e.sr = sr; e.se = se; e.go = go; e.w = w;
    return e;
  endfunction

  function automatic vec_t mv(input logic nf, input logic pl, input logic pr,
                              input logic gr, input exp_t e, input string nm);
    vec_t v;
    v.nf = nf; v.pl = pl; v.pr = pr; v.gr = gr; v.e = e; v.nm = nm;
    return v;
  endfunction

  task automatic check_pop();
    exp_t  e;
    exp_t  a;
    string nm;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_underflow: no expected entry queued");
      return;
    end
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    a  = mk(seg_l, seg_r, serve_en, game_over, winner);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got seg_l=%h seg_r=%h serve_en=%b game_over=%b winner=%b, want seg_l=%h seg_r=%h serve_en=%b game_over=%b winner=%b",
               nm, a.sl, a.sr, a.se, a.go, a.w, e.sl, e.sr, e.se, e.go, e.w);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, sample just after the rising edge.
  task automatic step(input logic nf, input logic pl, input logic pr, input logic gr,
                      input exp_t e, input string nm);
    @(negedge clk);
    new_frame = nf; point_l = pl; point_r = pr; game_reset = gr;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl [15];
    seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
    seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
    seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;

    tbl[0]  = mv(0, 0, 0, 0, mk(7'h3F, 7'h3F, 1, 0, 2'b00), "idle_play");
    tbl[1]  = mv(0, 1, 0, 0, mk(7'h3F, 7'h3F, 0, 0, 2'b00), "point_l_enters_hold");
    tbl[2]  = mv(1, 0, 0, 0, mk(7'h06, 7'h3F, 0, 0, 2'b00), "hold_frame1_seg_l");
    tbl[3]  = mv(0, 0, 1, 0, mk(7'h06, 7'h3F, 0, 0, 2'b00), "hold_point_r_ignored_a");
    tbl[4]  = mv(1, 0, 0, 0, mk(7'h06, 7'h3F, 0, 0, 2'b00), "hold_frame2");
    tbl[5]  = mv(0, 0, 1, 0, mk(7'h06, 7'h3F, 0, 0, 2'b00), "hold_point_r_ignored_b");
    tbl[6]  = mv(1, 0, 0, 0, mk(7'h06, 7'h3F, 1, 0, 2'b00), "hold_frame3_back_to_play");
    tbl[7]  = mv(0, 1, 1, 0, mk(7'h06, 7'h3F, 1, 0, 2'b00), "simultaneous_points");
    tbl[8]  = mv(1, 0, 0, 0, mk(7'h06, 7'h3F, 1, 0, 2'b00), "simultaneous_no_change");
    tbl[9]  = mv(1, 0, 1, 0, mk(7'h06, 7'h3F, 0, 0, 2'b00), "point_with_frame_old_disp");
    tbl[10] = mv(1, 0, 0, 0, mk(7'h06, 7'h06, 0, 0, 2'b00), "next_frame_new_disp");
    tbl[11] = mv(1, 0, 0, 0, mk(7'h06, 7'h06, 0, 0, 2'b00), "hold_frame2_b");
    tbl[12] = mv(1, 0, 0, 0, mk(7'h06, 7'h06, 1, 0, 2'b00), "hold_frame3_b");
    tbl[13] = mv(0, 0, 0, 1, mk(7'h06, 7'h06, 1, 0, 2'b00), "game_reset_in_play");
    tbl[14] = mv(1, 0, 0, 0, mk(7'h3F, 7'h3F, 1, 0, 2'b00), "frame_after_reset");

    new_frame = 0; point_l = 0; point_r = 0; game_reset = 0;
    rst_n = 1'b0;
    #12;
    exp_q.push_back(mk(7'h3F, 7'h3F, 1, 0, 2'b00));
    name_q.push_back("reset_state");
    check_pop();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].nf, tbl[i].pl, tbl[i].pr, tbl[i].gr, tbl[i].e, tbl[i].nm);
    end

    // Game_reset during HOLD returns straight to PLAY.
    step(0, 1, 0, 0, mk(7'h3F, 7'h3F, 0, 0, 2'b00), "hold_before_reset");
    step(0, 0, 0, 1, mk(7'h3F, 7'h3F, 1, 0, 2'b00), "game_reset_in_hold");
    step(1, 0, 0, 0, mk(7'h3F, 7'h3F, 1, 0, 2'b00), "frame_after_hold_reset");

    // Right player runs to WIN_SCORE with holds elapsing between points.
    disp_r = 7'h3F;
    for (int k = 1; k <= 7; k++) begin
      if (k < 7) begin
        step(0, 0, 1, 0, mk(7'h3F, disp_r, 0, 0, 2'b00), "win_run_point");
        disp_r = seg_tab[k];
        step(1, 0, 0, 0, mk(7'h3F, disp_r, 0, 0, 2'b00), "win_run_frame1");
        step(1, 0, 0, 0, mk(7'h3F, disp_r, 0, 0, 2'b00), "win_run_frame2");
        step(1, 0, 0, 0, mk(7'h3F, disp_r, 1, 0, 2'b00), "win_run_frame3");
      end else begin
        step(0, 0, 1, 0, mk(7'h3F, disp_r, 0, 1, 2'b10), "winning_point");
      end
    end
    step(1, 0, 0, 0, mk(7'h3F, 7'h07, 0, 1, 2'b10), "over_display_seven");
    step(0, 0, 1, 0, mk(7'h3F, 7'h07, 0, 1, 2'b10), "over_point_r_ignored");
    step(1, 0, 0, 0, mk(7'h3F, 7'h07, 0, 1, 2'b10), "over_persists");

    // New game with a competing point in the same cycle.
    step(0, 1, 0, 1, mk(7'h3F, 7'h07, 1, 0, 2'b00), "new_game_priority");
    step(1, 0, 0, 0, mk(7'h3F, 7'h3F, 1, 0, 2'b00), "new_game_display");

    // Asynchronous reset in the middle of a HOLD.
    step(0, 1, 0, 0, mk(7'h3F, 7'h3F, 0, 0, 2'b00), "pre_async_point");
    step(1, 0, 0, 0, mk(7'h06, 7'h3F, 0, 0, 2'b00), "pre_async_frame");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(7'h3F, 7'h3F, 1, 0, 2'b00));
    name_q.push_back("async_reset_mid_hold");
    check_pop();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, mk(7'h3F, 7'h3F, 1, 0, 2'b00), "after_async_idle");
    step(0, 1, 0, 0, mk(7'h3F, 7'h3F, 0, 0, 2'b00), "after_async_point");
    step(1, 0, 0, 0, mk(7'h06, 7'h3F, 0, 0, 2'b00), "after_async_frame");

    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_leftover: %0d entries still queued, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
